mb_sync_tx_pacer: RTL

// - Source-domain stage that sits directly upstream of the multibit level synchronizer (mb_sync).
// - Accepts a valid/ready word stream and buffers it in a small FIFO.
// - Presents one word at a time on o_data and raises o_valid as a rising-edge pulse.
// - Enforces a minimum low gap between pulses so that no toggle, and no word, is lost in the crossing.
// - Runs entirely on i_src_clock; it has no knowledge of the destination clock (open-loop pacing).

---
 rtl/mb_sync_pkg.sv | 7 +
 rtl/mb_sync_tx_pacer_if.sv | 12 +
 rtl/mb_src_fifo.sv | 42 ++++
 rtl/mb_sync_tx_pacer.sv | 89 ++++++++
 4 files changed

// File: rtl/mb_sync_pkg.sv
// mb_sync_pkg: shared types and sizing helpers for the multibit-synchronizer source side.
package mb_sync_pkg;
   typedef enum logic [1:0] {IDLE, SEND, HOLD} pacer_state_t;
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/mb_sync_tx_pacer_if.sv
// mb_sync_tx_pacer_if: upstream valid/ready stream plus paced word/pulse output toward mb_sync.
interface mb_sync_tx_pacer_if #(parameter int NB = 8, parameter int DEPTH = 4);
   logic [NB-1:0]          i_data;
   logic                   i_valid;
   logic                   o_ready;
   logic [NB-1:0]          o_data;
   logic                   o_valid;
   logic [$clog2(DEPTH):0] o_level;
   logic                   o_busy;
   modport slave (input i_data, i_valid, output o_ready, o_data, o_valid, o_level, o_busy);
   modport master (output i_data, i_valid, input o_ready, o_data, o_valid, o_level, o_busy);
endinterface

// File: rtl/mb_src_fifo.sv
// mb_src_fifo: small source-clock FIFO with a combinational head word.
module mb_src_fifo
   import mb_sync_pkg::*;
#(
   parameter int NB    = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_src_clock,
   input  logic                   i_reset,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [NB-1:0]          i_wr_data,
   output logic [NB-1:0]          o_rd_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int PW = ptr_w(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;
   logic [NB-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [LW-1:0] r_count;
   // storage needs no reset: only entries counted by r_count are ever read
   always_ff @(posedge i_src_clock)
      if (i_push) r_mem[r_wr] <= i_wr_data;
   always_ff @(posedge i_src_clock) begin
      if (i_reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= i_push ? r_wr + PW'(1) : r_wr;
         r_rd    <= i_pop ? r_rd + PW'(1) : r_rd;
         r_count <= r_count + LW'(i_push) - LW'(i_pop);
      end
   end
   assign o_rd_data = r_mem[r_rd];
   assign o_full    = (r_count == LW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
endmodule

// File: rtl/mb_sync_tx_pacer.sv
// mb_sync_tx_pacer: buffers a word stream and emits one word per o_valid pulse with an
// enforced low gap, so the downstream level synchronizer never misses a toggle.
module mb_sync_tx_pacer
   import mb_sync_pkg::*;
#(
   parameter int NB        = 8,
   parameter int DEPTH     = 4,
   parameter int PULSE_LEN = 1,
   parameter int GAP       = 8
) (
   input  logic                 i_src_clock,
   input  logic                 i_reset,
   mb_sync_tx_pacer_if.slave    io_bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2((PULSE_LEN > GAP) ? PULSE_LEN : GAP) + 1;
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and >= 2");
   end
   if (PULSE_LEN < 1) begin : g_bad_pulse
      $error("PULSE_LEN must be >= 1");
   end
   if (GAP < 1) begin : g_bad_gap
      $error("GAP must be >= 1");
   end
   pacer_state_t  r_state;
   logic [CW-1:0] r_cnt;
   logic [NB-1:0] r_data;
   logic          r_valid;
   logic [NB-1:0] w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [LW-1:0] w_level;
   assign w_push = io_bus.i_valid & ~w_full;
   assign w_pop  = (r_state == IDLE) & ~w_empty;
   mb_src_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
      .i_src_clock (i_src_clock),
      .i_reset     (i_reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_wr_data   (io_bus.i_data),
      .o_rd_data   (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_level     (w_level)
   );
   // every word passes through IDLE, so pulses are spaced PULSE_LEN+GAP+1 cycles apart
   always_ff @(posedge i_src_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_valid <= ~w_empty;
               if (~w_empty) begin
                  r_data  <= w_head;
                  r_cnt   <= '0;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (r_cnt == CW'(PULSE_LEN - 1)) begin
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            HOLD: begin
               r_valid <= 1'b0;
               r_cnt   <= (r_cnt == CW'(GAP - 1)) ? r_cnt : r_cnt + CW'(1);
               r_state <= (r_cnt == CW'(GAP - 1)) ? IDLE : HOLD;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io_bus.o_ready = ~w_full;
   assign io_bus.o_data  = r_data;
   assign io_bus.o_valid = r_valid;
   assign io_bus.o_level = w_level;
   assign io_bus.o_busy  = (r_state != IDLE) | (w_level != '0);
endmodule
